// File: rtl/afu_csr_pkg.sv
// ---------------------------------------------------------------------------
// afu_csr_pkg
// Shared definitions for the AFU MMIO CSR block:
//   - a minimal CCI-P Rx/Tx struct subset (only the MMIO-related fields)
//   - CSR byte addresses, DFH field constants, ERR_CTL bit positions
//   - injection FSM state enum
//   - dfhValue() helper that assembles the Device Feature Header word
// MMIO data is carried as 64 bits, which is all an MMIO access ever uses.
// ---------------------------------------------------------------------------
package afu_csr_pkg;

  // MMIO request header as seen on the c0 Rx channel.
  // address is in 32-bit word units; byte address = address << 2.
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  // Tx channels: c0/c1 are memory request channels that this block never uses.
  typedef struct packed {
    logic [63:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] data;
    logic        valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  // CSR byte addresses (byte address = hdr.address << 2, so 18 bits wide).
  localparam int CSR_ADDR_W = 18;
  typedef logic [CSR_ADDR_W-1:0] t_csr_addr;

  localparam t_csr_addr CSR_DFH      = 18'h00000;
  localparam t_csr_addr CSR_AFU_ID_L = 18'h00008;
  localparam t_csr_addr CSR_AFU_ID_H = 18'h00010;
  localparam t_csr_addr CSR_RSVD0    = 18'h00018;
  localparam t_csr_addr CSR_RSVD1    = 18'h00020;
  localparam t_csr_addr CSR_SCRATCH  = 18'h00040;
  localparam t_csr_addr CSR_RD_CNT   = 18'h00048;
  localparam t_csr_addr CSR_ERR_CTL  = 18'h00050;

  // MMIO length encoding: only 64-bit writes are honoured.
  localparam logic [1:0] MMIO_LEN_32 = 2'b00;
  localparam logic [1:0] MMIO_LEN_64 = 2'b01;

  // DFH layout: [63:60] feature type, [40] end-of-list, [39:16] next offset.
  localparam logic [3:0] DFH_TYPE_AFU = 4'h1;
  localparam int         DFH_TYPE_LSB = 60;
  localparam int         DFH_EOL_BIT  = 40;
  localparam int         DFH_NEXT_LSB = 16;

  // ERR_CTL bit positions.
  localparam int ERR_CTL_TRIG_BIT = 0;
  localparam int ERR_CTL_BUSY_BIT = 1;
  localparam int ERR_CTL_CNT_LSB  = 16;

  // Unsolicited response produced by the error injector.
  localparam logic [8:0]  INJ_TID  = 9'h1FF;
  localparam logic [63:0] INJ_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    INJ_IDLE  = 2'd0,
    INJ_ARM   = 2'd1,
    INJ_ISSUE = 2'd2,
    INJ_DONE  = 2'd3
  } t_inj_state;

  // Assemble the DFH word for an AFU that is the last entry in its list.
  function automatic logic [63:0] dfhValue(input logic [23:0] nextOff);
    logic [63:0] v;
    v = '0;
    v[DFH_TYPE_LSB +: 4]  = DFH_TYPE_AFU;
    v[DFH_EOL_BIT]        = 1'b1;
    v[DFH_NEXT_LSB +: 24] = nextOff;
    return v;
  endfunction

endpackage

// File: rtl/afu_err_inject_fsm.sv
// ---------------------------------------------------------------------------
// afu_err_inject_fsm
// Sequencer for the spurious MMIO read response injector.
// Ports:
//   clk_i        - clock
//   rst_i        - asynchronous active-high reset
//   trigger_i    - one-cycle pulse from an ERR_CTL trigger write
//   slot_free_i  - high when no real read response is due next cycle
//   issue_o      - load the injected response into the c2 output register
//                  this cycle (it becomes visible while the FSM is in ISSUE)
//   busy_o       - FSM is not idle; further triggers are ignored
//   cnt_o        - number of completed injections, wraps at 16 bits
// ---------------------------------------------------------------------------
module afu_err_inject_fsm
  import afu_csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trigger_i,
  input  logic        slot_free_i,
  output logic        issue_o,
  output logic        busy_o,
  output logic [15:0] cnt_o
);

  t_inj_state  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  // State and injection counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INJ_IDLE;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The issue pulse is raised on the ARM->ISSUE transition
  // so that the registered c2 output carries the injected response exactly
  // during the ISSUE cycle, a cycle in which no real response can appear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue_o = 1'b0;
    case (state_q)
      INJ_IDLE: begin
        if (trigger_i) state_d = INJ_ARM;
      end
      INJ_ARM: begin
        if (slot_free_i) begin
          issue_o = 1'b1;
          state_d = INJ_ISSUE;
        end
      end
      INJ_ISSUE: begin
        state_d = INJ_DONE;
      end
      INJ_DONE: begin
        cnt_d   = cnt_q + 16'h0001;
        state_d = INJ_IDLE;
      end
      default: begin
        state_d = INJ_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != INJ_IDLE);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/afu_mmio_csr.sv
// ---------------------------------------------------------------------------
// afu_mmio_csr
// CCI-P MMIO CSR block for an AFU: DFH, AFU UUID, scratch register and an
// error-injection control register that can emit one unsolicited MMIO read
// response (tid 0x1FF) into a free slot of the response stream.
// Parameters:
//   AFU_ID_L / AFU_ID_H - low/high 64 bits of the AFU UUID
//   DFH_NEXT            - next-DFH byte offset reported in the DFH
// Ports:
//   Clk_400        - the only clock, rising edge
//   SoftReset      - asynchronous active-high reset
//   cp2af_sRxPort  - registered CCI-P Rx; only c0 MMIO fields are used
//   af2cp_sTxPort  - CCI-P Tx; c0/c1 idle, c2 carries MMIO read responses
// Build option:
//   AFU_MMIO_RD_CNT_EN - adds read-only CSR 0x48 counting accepted reads;
//                        when undefined, 0x48 reads as 0 and no counter exists.
// Read responses appear 2 cycles after the request (request register + c2
// output register). Writes are registered and take effect one cycle later.
// ---------------------------------------------------------------------------
module afu_mmio_csr
  import afu_csr_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0,
  parameter logic [23:0] DFH_NEXT = 24'h0
) (
  input  logic        Clk_400,
  input  logic        SoftReset,
  input  t_if_ccip_Rx cp2af_sRxPort,
  output t_if_ccip_Tx af2cp_sTxPort
);

  logic        rdReq;
  logic        wrReq;
  t_csr_addr   reqAddr;
  logic [63:0] rdData;
  logic [63:0] errCtlValue;

  logic        rdValid_q;
  logic [8:0]  rdTid_q;
  logic [63:0] rdData_q;

  logic        c2Valid_q, c2Valid_d;
  logic [8:0]  c2Tid_q, c2Tid_d;
  logic [63:0] c2Data_q, c2Data_d;

  logic        wrValid_q;
  t_csr_addr   wrAddr_q;
  logic [63:0] wrData_q;

  logic [63:0] scratch_q;

  logic        injTrigger;
  logic        injIssue;
  logic        injBusy;
  logic [15:0] injCnt;

  // Rx fields this block has no use for.
  logic        unusedRx;
  assign unusedRx = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull,
                      cp2af_sRxPort.c0.rspValid, cp2af_sRxPort.c0.hdr.rsvd};

  assign rdReq   = cp2af_sRxPort.c0.mmioRdValid;
  assign wrReq   = cp2af_sRxPort.c0.mmioWrValid;
  assign reqAddr = {cp2af_sRxPort.c0.hdr.address, 2'b00};

  assign errCtlValue = {32'h0, injCnt, 14'h0, injBusy, 1'b0};

`ifdef AFU_MMIO_RD_CNT_EN
  logic [63:0] rdCnt_q;

  // Count every accepted MMIO read, whatever its address or length.
  always_ff @(posedge Clk_400 or posedge SoftReset) begin
    if (SoftReset) begin
      rdCnt_q <= 64'h0;
    end else if (rdReq) begin
      rdCnt_q <= rdCnt_q + 64'h1;
    end
  end
`endif

  // Read decode. Reads ignore length: a 32-bit read gets the full 64-bit
  // CSR value, and anything unmapped returns 0.
  always_comb begin
    rdData = 64'h0;
    case (reqAddr)
      CSR_DFH:      rdData = dfhValue(DFH_NEXT);
      CSR_AFU_ID_L: rdData = AFU_ID_L;
      CSR_AFU_ID_H: rdData = AFU_ID_H;
      CSR_RSVD0:    rdData = 64'h0;
      CSR_RSVD1:    rdData = 64'h0;
      CSR_SCRATCH:  rdData = scratch_q;
`ifdef AFU_MMIO_RD_CNT_EN
      CSR_RD_CNT:   rdData = rdCnt_q;
`endif
      CSR_ERR_CTL:  rdData = errCtlValue;
      default:      rdData = 64'h0;
    endcase
  end

  // Read pipeline stage 1: capture every read request with its decoded data.
  always_ff @(posedge Clk_400 or posedge SoftReset) begin
    if (SoftReset) begin
      rdValid_q <= 1'b0;
      rdTid_q   <= 9'h0;
      rdData_q  <= 64'h0;
    end else begin
      rdValid_q <= rdReq;
      rdTid_q   <= cp2af_sRxPort.c0.hdr.tid;
      rdData_q  <= rdData;
    end
  end

  // c2 output mux: a real response always wins. The injector only issues
  // when stage 1 is empty, so the second branch never hides a real read.
  always_comb begin
    c2Valid_d = 1'b0;
    c2Tid_d   = rdTid_q;
    c2Data_d  = rdData_q;
    if (rdValid_q) begin
      c2Valid_d = 1'b1;
    end else if (injIssue) begin
      c2Valid_d = 1'b1;
      c2Tid_d   = INJ_TID;
      c2Data_d  = INJ_DATA;
    end
  end

  // Read pipeline stage 2: the registered c2 output.
  always_ff @(posedge Clk_400 or posedge SoftReset) begin
    if (SoftReset) begin
      c2Valid_q <= 1'b0;
      c2Tid_q   <= 9'h0;
      c2Data_q  <= 64'h0;
    end else begin
      c2Valid_q <= c2Valid_d;
      c2Tid_q   <= c2Tid_d;
      c2Data_q  <= c2Data_d;
    end
  end

  // Write request register; 32-bit writes are dropped here.
  always_ff @(posedge Clk_400 or posedge SoftReset) begin
    if (SoftReset) begin
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= 64'h0;
    end else begin
      wrValid_q <= wrReq && (cp2af_sRxPort.c0.hdr.length == MMIO_LEN_64);
      wrAddr_q  <= reqAddr;
      wrData_q  <= cp2af_sRxPort.c0.data;
    end
  end

  // SCRATCH is the only writable storage; writes elsewhere have no effect.
  always_ff @(posedge Clk_400 or posedge SoftReset) begin
    if (SoftReset) begin
      scratch_q <= 64'h0;
    end else if (wrValid_q && (wrAddr_q == CSR_SCRATCH)) begin
      scratch_q <= wrData_q;
    end
  end

  assign injTrigger = wrValid_q && (wrAddr_q == CSR_ERR_CTL) &&
                      wrData_q[ERR_CTL_TRIG_BIT];

  afu_err_inject_fsm u_inject (
    .clk_i       (Clk_400),
    .rst_i       (SoftReset),
    .trigger_i   (injTrigger),
    .slot_free_i (!rdValid_q),
    .issue_o     (injIssue),
    .busy_o      (injBusy),
    .cnt_o       (injCnt)
  );

  // Tx drive: only c2 is ever active, straight from registers.
  always_comb begin
    af2cp_sTxPort                = '0;
    af2cp_sTxPort.c2.mmioRdValid = c2Valid_q;
    af2cp_sTxPort.c2.hdr.tid     = c2Tid_q;
    af2cp_sTxPort.c2.data        = c2Data_q;
  end

endmodule

// File: tb/tb_afu_mmio_csr.sv
// ---------------------------------------------------------------------------
// tb_afu_mmio_csr
// Directed testbench for afu_mmio_csr. Every c2 response is logged with the
// cycle it appeared in; each test inspects that log against hand-computed
// expectations. Honours AFU_MMIO_RD_CNT_EN for the RD_CNT expectation.
// ---------------------------------------------------------------------------
module tb_afu_mmio_csr;
  import afu_csr_pkg::*;

  localparam logic [63:0] TB_ID_L    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TB_ID_H    = 64'hFEDC_BA98_7654_3210;
  localparam logic [23:0] TB_NEXT    = 24'h001000;
  localparam logic [63:0] TB_DFH     = 64'h1000_0100_1000_0000;
  localparam logic [63:0] TB_SCRATCH = 64'h1234_5678_9ABC_DEF0;
`ifdef AFU_MMIO_RD_CNT_EN
  localparam logic [63:0] TB_RDCNT   = 64'd3;
`else
  localparam logic [63:0] TB_RDCNT   = 64'd0;
`endif

  typedef struct {
    int          cyc;
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  logic        Clk_400 = 1'b0;
  logic        SoftReset = 1'b0;
  t_if_ccip_Rx rx;
  t_if_ccip_Tx tx;

  int   cyc = 0;
  int   passCount = 0;
  int   checkCount = 0;
  bit   sideValidSeen = 1'b0;
  rsp_t rspQ[$];

  afu_mmio_csr #(
    .AFU_ID_L (TB_ID_L),
    .AFU_ID_H (TB_ID_H),
    .DFH_NEXT (TB_NEXT)
  ) dut (
    .Clk_400       (Clk_400),
    .SoftReset     (SoftReset),
    .cp2af_sRxPort (rx),
    .af2cp_sTxPort (tx)
  );

  always #5 Clk_400 = ~Clk_400;

  always @(posedge Clk_400) cyc <= cyc + 1;

  // Log every c2 response on the falling edge, tagged with its cycle.
  always @(negedge Clk_400) begin
    rsp_t r;
    if (tx.c2.mmioRdValid === 1'b1) begin
      r.cyc  = cyc;
      r.tid  = tx.c2.hdr.tid;
      r.data = tx.c2.data;
      rspQ.push_back(r);
    end
    if (tx.c0.valid !== 1'b0 || tx.c1.valid !== 1'b0) sideValidSeen = 1'b1;
  end

  // Drive one cycle of Rx stimulus; reqCyc is the cycle it is presented in.
  task automatic applyStimulus(input bit rd, input bit wr, input t_csr_addr addr,
                               input logic [1:0] len, input logic [8:0] tid,
                               input logic [63:0] data, output int reqCyc);
    @(posedge Clk_400);
    #1;
    rx = '0;
    rx.c0.mmioRdValid  = rd;
    rx.c0.mmioWrValid  = wr;
    rx.c0.hdr.address  = addr[17:2];
    rx.c0.hdr.length   = len;
    rx.c0.hdr.tid      = tid;
    rx.c0.data         = data;
    reqCyc = cyc;
  endtask

  task automatic idleCycles(input int n);
    int c;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 2'b00, 9'h0, 64'h0, c);
  endtask

  // Single read followed by enough idle cycles for its response to land.
  task automatic readCsr(input t_csr_addr addr, input logic [1:0] len,
                         input logic [8:0] tid, output int reqCyc);
    rspQ.delete();
    applyStimulus(1, 0, addr, len, tid, 64'h0, reqCyc);
    idleCycles(4);
  endtask

  task automatic writeCsr(input t_csr_addr addr, input logic [1:0] len,
                          input logic [63:0] data);
    int c;
    applyStimulus(0, 1, addr, len, 9'h0, data, c);
    idleCycles(2);
  endtask

  task automatic test_reset();
    int r;
    rx = '0;
    #1 SoftReset = 1'b1;
    repeat (3) @(posedge Clk_400);
    @(negedge Clk_400);
    checkCount++;
    if (tx.c2.mmioRdValid !== 1'b0)
      $display("[TB] FAIL reset_c2_valid got=%b want=0", tx.c2.mmioRdValid);
    else passCount++;
    checkCount++;
    if (tx.c0.valid !== 1'b0 || tx.c1.valid !== 1'b0)
      $display("[TB] FAIL reset_c0c1_valid got=%b%b want=00", tx.c0.valid, tx.c1.valid);
    else passCount++;
    @(posedge Clk_400);
    #1 SoftReset = 1'b0;
    idleCycles(2);
    readCsr(CSR_SCRATCH, MMIO_LEN_64, 9'h003, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== 64'h0 || rspQ[0].cyc != r + 2)
      $display("[TB] FAIL reset_scratch got_n=%0d got=%h want=0", rspQ.size(),
               rspQ.size() > 0 ? rspQ[0].data : 64'hx);
    else passCount++;
  endtask

  task automatic test_id_read();
    int r;
    t_csr_addr   addrs[7] = '{CSR_AFU_ID_L, CSR_DFH, CSR_AFU_ID_H, CSR_RSVD0,
                              CSR_RSVD1, 18'h00060, CSR_AFU_ID_H};
    logic [1:0]  lens[7]  = '{MMIO_LEN_64, MMIO_LEN_64, MMIO_LEN_64, MMIO_LEN_64,
                              MMIO_LEN_64, MMIO_LEN_64, MMIO_LEN_32};
    logic [63:0] exps[7]  = '{TB_ID_L, TB_DFH, TB_ID_H, 64'h0, 64'h0, 64'h0, TB_ID_H};
    logic [8:0]  tids[7]  = '{9'h005, 9'h021, 9'h102, 9'h033, 9'h044, 9'h055, 9'h1FE};
    for (int i = 0; i < 7; i++) begin
      readCsr(addrs[i], lens[i], tids[i], r);
      checkCount++;
      if (rspQ.size() != 1)
        $display("[TB] FAIL read_count addr=%h got=%0d want=1", addrs[i], rspQ.size());
      else if (rspQ[0].cyc != r + 2 || rspQ[0].tid !== tids[i] || rspQ[0].data !== exps[i])
        $display("[TB] FAIL read addr=%h got cyc=%0d tid=%h data=%h want cyc=%0d tid=%h data=%h",
                 addrs[i], rspQ[0].cyc, rspQ[0].tid, rspQ[0].data, r + 2, tids[i], exps[i]);
      else passCount++;
    end
  endtask

  task automatic test_scratch();
    int r;
    writeCsr(CSR_SCRATCH, MMIO_LEN_64, TB_SCRATCH);
    readCsr(CSR_SCRATCH, MMIO_LEN_64, 9'h011, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== TB_SCRATCH)
      $display("[TB] FAIL scratch_wr64 got=%h want=%h",
               rspQ.size() > 0 ? rspQ[0].data : 64'hx, TB_SCRATCH);
    else passCount++;
    writeCsr(CSR_SCRATCH, MMIO_LEN_32, 64'hFFFF_FFFF_FFFF_FFFF);
    readCsr(CSR_SCRATCH, MMIO_LEN_64, 9'h012, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== TB_SCRATCH)
      $display("[TB] FAIL scratch_wr32_ignored got=%h want=%h",
               rspQ.size() > 0 ? rspQ[0].data : 64'hx, TB_SCRATCH);
    else passCount++;
    writeCsr(CSR_AFU_ID_L, MMIO_LEN_64, 64'h0);
    readCsr(CSR_AFU_ID_L, MMIO_LEN_64, 9'h013, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== TB_ID_L)
      $display("[TB] FAIL ro_write_ignored got=%h want=%h",
               rspQ.size() > 0 ? rspQ[0].data : 64'hx, TB_ID_L);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    int          req[8];
    logic [63:0] exp[8];
    t_csr_addr   a;
    rspQ.delete();
    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0: begin a = CSR_AFU_ID_L; exp[i] = TB_ID_L; end
        1: begin a = CSR_AFU_ID_H; exp[i] = TB_ID_H; end
        default: begin a = CSR_SCRATCH; exp[i] = TB_SCRATCH; end
      endcase
      applyStimulus(1, 0, a, MMIO_LEN_64, 9'(i), 64'h0, req[i]);
    end
    idleCycles(4);
    checkCount++;
    if (rspQ.size() != 8)
      $display("[TB] FAIL b2b_count got=%0d want=8", rspQ.size());
    else begin
      passCount++;
      for (int i = 0; i < 8; i++) begin
        checkCount++;
        if (rspQ[i].cyc != req[i] + 2 || rspQ[i].tid !== 9'(i) || rspQ[i].data !== exp[i])
          $display("[TB] FAIL b2b[%0d] got cyc=%0d tid=%h data=%h want cyc=%0d tid=%h data=%h",
                   i, rspQ[i].cyc, rspQ[i].tid, rspQ[i].data, req[i] + 2, 9'(i), exp[i]);
        else passCount++;
      end
    end
  endtask

  task automatic test_inject();
    int          base, c, r, nInj, injCyc;
    logic [8:0]  expTid[8];
    int          expCyc[8];
    logic [63:0] expData[8];
    bit          found;
    rspQ.delete();
    // Stream: 2 reads, 2 trigger writes (second lands while busy), 6 reads.
    applyStimulus(1, 0, CSR_AFU_ID_L, MMIO_LEN_64, 9'h010, 64'h0, base);
    applyStimulus(1, 0, CSR_AFU_ID_L, MMIO_LEN_64, 9'h011, 64'h0, c);
    applyStimulus(0, 1, CSR_ERR_CTL, MMIO_LEN_64, 9'h0, 64'h1, c);
    applyStimulus(0, 1, CSR_ERR_CTL, MMIO_LEN_64, 9'h0, 64'h1, c);
    applyStimulus(1, 0, CSR_ERR_CTL, MMIO_LEN_64, 9'h012, 64'h0, c);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, CSR_AFU_ID_L, MMIO_LEN_64, 9'(9'h013 + i), 64'h0, c);
    idleCycles(4);
    // Read responses: cycles base+2, base+3, then base+6..base+11.
    expTid[0] = 9'h010; expCyc[0] = base + 2; expData[0] = TB_ID_L;
    expTid[1] = 9'h011; expCyc[1] = base + 3; expData[1] = TB_ID_L;
    expTid[2] = 9'h012; expCyc[2] = base + 6; expData[2] = 64'h2;
    for (int i = 3; i < 8; i++) begin
      expTid[i] = 9'(9'h010 + i); expCyc[i] = base + 4 + i; expData[i] = TB_ID_L;
    end
    checkCount++;
    if (rspQ.size() != 9) $display("[TB] FAIL inj_rsp_count got=%0d want=9", rspQ.size());
    else passCount++;
    nInj = 0;
    injCyc = -1;
    foreach (rspQ[k]) begin
      if (rspQ[k].tid === INJ_TID) begin
        nInj++;
        injCyc = rspQ[k].cyc;
        checkCount++;
        if (rspQ[k].data !== INJ_DATA)
          $display("[TB] FAIL inj_data got=%h want=%h", rspQ[k].data, INJ_DATA);
        else passCount++;
      end
    end
    checkCount++;
    if (nInj != 1 || injCyc != base + 5)
      $display("[TB] FAIL inj_slot got n=%0d cyc=%0d want n=1 cyc=%0d", nInj, injCyc, base + 5);
    else passCount++;
    for (int i = 0; i < 8; i++) begin
      found = 1'b0;
      foreach (rspQ[k])
        if (rspQ[k].tid === expTid[i] && rspQ[k].cyc == expCyc[i] && rspQ[k].data === expData[i])
          found = 1'b1;
      checkCount++;
      if (!found)
        $display("[TB] FAIL inj_stream tid=%h got=absent want cyc=%0d data=%h",
                 expTid[i], expCyc[i], expData[i]);
      else passCount++;
    end
    readCsr(CSR_ERR_CTL, MMIO_LEN_64, 9'h020, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== 64'h0000_0000_0001_0000)
      $display("[TB] FAIL err_ctl_after got=%h want=%h",
               rspQ.size() > 0 ? rspQ[0].data : 64'hx, 64'h0000_0000_0001_0000);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int c, r;
    rspQ.delete();
    applyStimulus(0, 1, CSR_ERR_CTL, MMIO_LEN_64, 9'h0, 64'h1, c);
    applyStimulus(1, 0, CSR_SCRATCH, MMIO_LEN_64, 9'h0AA, 64'h0, c);
    @(posedge Clk_400);
    #1;
    rx = '0;
    SoftReset = 1'b1;
    @(negedge Clk_400);
    checkCount++;
    if (tx.c2.mmioRdValid !== 1'b0)
      $display("[TB] FAIL midreset_c2_valid got=%b want=0", tx.c2.mmioRdValid);
    else passCount++;
    repeat (2) @(posedge Clk_400);
    #1 SoftReset = 1'b0;
    idleCycles(8);
    checkCount++;
    if (rspQ.size() != 0)
      $display("[TB] FAIL midreset_no_rsp got=%0d want=0", rspQ.size());
    else passCount++;
    readCsr(CSR_SCRATCH, MMIO_LEN_64, 9'h0AB, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== 64'h0)
      $display("[TB] FAIL midreset_scratch got=%h want=0",
               rspQ.size() > 0 ? rspQ[0].data : 64'hx);
    else passCount++;
    readCsr(CSR_ERR_CTL, MMIO_LEN_64, 9'h0AC, r);
    checkCount++;
    if (rspQ.size() != 1 || rspQ[0].data !== 64'h0)
      $display("[TB] FAIL midreset_err_ctl got=%h want=0",
               rspQ.size() > 0 ? rspQ[0].data : 64'hx);
    else passCount++;
  endtask

  task automatic test_rd_cnt();
    int c;
    @(posedge Clk_400);
    #1 SoftReset = 1'b1;
    repeat (2) @(posedge Clk_400);
    #1 SoftReset = 1'b0;
    idleCycles(2);
    rspQ.delete();
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, CSR_AFU_ID_L, MMIO_LEN_64, 9'(9'h040 + i), 64'h0, c);
    applyStimulus(1, 0, CSR_RD_CNT, MMIO_LEN_64, 9'h030, 64'h0, c);
    idleCycles(4);
    checkCount++;
    if (rspQ.size() != 4 || rspQ[3].tid !== 9'h030 || rspQ[3].data !== TB_RDCNT)
      $display("[TB] FAIL rd_cnt got_n=%0d got=%h want=%h", rspQ.size(),
               rspQ.size() > 3 ? rspQ[3].data : 64'hx, TB_RDCNT);
    else passCount++;
  endtask

  task automatic test_tx_quiet();
    checkCount++;
    if (sideValidSeen)
      $display("[TB] FAIL c0c1_valid_seen got=1 want=0");
    else passCount++;
  endtask

  initial begin
    rx = '0;
    test_reset();
    test_id_read();
    test_scratch();
    test_back_to_back();
    test_inject();
    test_reset_mid();
    test_rd_cnt();
    test_tx_quiet();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/afu_mmio_csr.md
AFU_MMIO_CSR -- requirements
Module: afu_mmio_csr

Interface
REQ-001 SHALL have parameter AFU_ID_L, default 64'h0, low 64 bits of the AFU UUID.
REQ-002 SHALL have parameter AFU_ID_H, default 64'h0, high 64 bits of the AFU UUID.
REQ-003 SHALL have parameter DFH_NEXT, default 24'h0, next-DFH offset field.
REQ-004 SHALL have port Clk_400, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port SoftReset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cp2af_sRxPort, input, t_if_ccip_Rx: the registered CCI-P Rx; only c0 MMIO fields are consumed.
REQ-007 SHALL have port af2cp_sTxPort, output, t_if_ccip_Tx: the CCI-P Tx fed to the interface register stage.

Function
REQ-008 SHALL decode byte address = hdr.address<<2 on c0.mmioRdValid / c0.mmioWrValid.
REQ-009 SHALL map CSRs: 0x00 DFH (type AFU, DFH_NEXT, EOL=1) RO; 0x08 AFU_ID_L RO; 0x10 AFU_ID_H RO; 0x18, 0x20 reserved RO 0; 0x40 SCRATCH RW 64b; 0x50 ERR_CTL.
REQ-010 SHALL define ERR_CTL: write with data[0]=1 triggers an injection; read returns {32'h0, inject_cnt[15:0], 14'h0, busy, 1'b0}.
REQ-011 SHALL answer every MMIO read, including unmapped addresses (data 0) and 32-bit reads (full 64-bit CSR value), exactly 2 cycles after the request cycle, with c2.hdr.tid equal to the request tid.
REQ-012 SHALL implement the read path as a 2-stage pipeline of {valid, tid, data}, accepting one read per cycle with no stall.
REQ-013 SHALL apply 64-bit writes (length 2'b01) only, in the cycle after the request; 32-bit writes and writes to RO/unmapped addresses SHALL be ignored.
REQ-014 SHALL drive c0.valid and c1.valid permanently 0.
REQ-015 SHALL run an injection FSM with states IDLE, ARM, ISSUE, DONE.
REQ-016 SHALL move from IDLE to ARM on a trigger write, and from ARM to ISSUE in the first cycle in which the read pipeline has no response due in the next cycle.
REQ-017 SHALL, in ISSUE, drive one unsolicited c2 mmioRdValid with tid 9'h1FF and data 64'hDEAD_BEEF_DEAD_BEEF, then go to DONE.
REQ-018 SHALL, in DONE, increment inject_cnt (16-bit, wraps 0xFFFF to 0x0000) and return to IDLE.
REQ-019 SHALL expose busy = (state != IDLE); trigger writes while busy SHALL be ignored.
REQ-020 SHALL give a real read response priority over ISSUE; the two SHALL never be driven in the same cycle.
REQ-021 SHALL register the c2 outputs, with no combinational path from sRx to sTx.

Reset
REQ-022 SHALL on SoftReset clear: c2 valid, pipeline valids, SCRATCH, inject_cnt; FSM to IDLE.
REQ-023 SHALL drop in-flight reads and any pending injection when reset asserts mid-operation, with no response after deassertion.
REQ-024 SHALL drive all af2cp_sTxPort valid bits 0 during reset.

Configuration
REQ-025 SHALL, with AFU_MMIO_RD_CNT_EN defined, add RO CSR 0x48 RD_CNT: a 64-bit count of accepted MMIO reads, cleared by reset and incremented on each read.
REQ-026 SHALL, without AFU_MMIO_RD_CNT_EN, have no RD_CNT counter logic; 0x48 reads as 0.

Structure
REQ-027 SHALL place the CSR byte-address localparams, DFH field constants, the ERR_CTL bit positions and the FSM state enum in package afu_csr_pkg.
REQ-028 SHALL implement the injection FSM and inject_cnt in sub-module afu_err_inject_fsm, with inputs trigger and slot_free and outputs issue, busy and cnt.

Verification
REQ-029 SHALL verify: read 0x08 with tid 0x05 at cycle N -> c2 valid at N+2, tid 0x05, data AFU_ID_L.
REQ-030 SHALL verify: 64-bit write 0x40 = 64'h1234_5678_9ABC_DEF0, then read -> same value; 32-bit write to 0x40 -> value unchanged.
REQ-031 SHALL verify: back-to-back reads on 8 consecutive cycles (tids 0..7) -> 8 consecutive responses, in order, each 2 cycles after its request.
REQ-032 SHALL verify: trigger via 0x50 during a continuous read stream -> spurious response (tid 0x1FF) only in a gap, and a following ERR_CTL read returns cnt=1, busy=0.
REQ-033 SHALL verify: SoftReset asserted one cycle after a read request -> no c2 valid ever produced; SCRATCH reads 0 after reset.
REQ-034 SHALL verify: with AFU_MMIO_RD_CNT_EN, 3 reads then a read of 0x48 -> returns 3; without the macro -> returns 0.
